// File: rtl/exec_stage_hs.sv
// ---------------------------------------------------------------------------
// exec_stage_hs
// Execute stage for a Y86-style processor with valid/ready handshakes on
// both sides. Computes valE and the cmov/jump condition, maintains the
// ZF/SF/OF condition-code register, and optionally runs an iterative
// shift-add unsigned multiply (OPq ifun=4) that holds the stage for WIDTH
// cycles.
//
// Parameters
//   WIDTH   datapath width (multiple of 8, >= 16); stack step is WIDTH/8
//   MUL_EN  1 enables the multiply encoding, 0 makes it illegal
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   icode, ifun              instruction codes
//   valA, valB, valC         operands
//   out_valid / out_ready    downstream handshake
//   out_icode, valE, cond    held result
//   bad_op                   illegal ifun for the held icode
//   ZF, SF, OF               condition-code register
// ---------------------------------------------------------------------------
module exec_stage_hs #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] valE,
  output logic             cond,
  output logic             bad_op,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WB_V = WIDTH'(WIDTH / 8);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t                 state_r;
  logic                   out_valid_r;
  logic [3:0]             out_icode_r;
  logic [WIDTH-1:0]       val_e_r;
  logic                   cond_r;
  logic                   bad_op_r;
  logic                   zf_r;
  logic                   sf_r;
  logic                   of_r;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]       mplier_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [CW-1:0]          cnt_r;

  logic                   in_ready_s;
  logic                   accept_s;
  logic [WIDTH-1:0]       res_val_s;
  logic                   res_cond_s;
  logic                   res_bad_s;
  logic                   res_of_s;
  logic                   cc_we_s;
  logic                   is_mul_s;
  logic [1:0]             cond_eval_s;
  logic [2*WIDTH-1:0]     acc_next_s;
  logic                   mul_last_s;

  // Condition evaluation from the CC register; returns {bad, cond}.
  function automatic logic [1:0] eval_cond(
    input logic [3:0] fn,
    input logic       zf,
    input logic       sf,
    input logic       of
  );
    logic [1:0] r;
    case (fn)
      4'h0:    r = {1'b0, 1'b1};
      4'h1:    r = {1'b0, (sf ^ of) | zf};
      4'h2:    r = {1'b0, sf ^ of};
      4'h3:    r = {1'b0, zf};
      4'h4:    r = {1'b0, ~zf};
      4'h5:    r = {1'b0, ~(sf ^ of)};
      4'h6:    r = {1'b0, ~(sf ^ of) & ~zf};
      default: r = {1'b1, 1'b0};
    endcase
    return r;
  endfunction

  // Handshake: accept only when idle and the output register is free or draining.
  always_comb begin
    in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
  end

  // Single-cycle result, condition and CC-update decode.
  always_comb begin
    res_val_s   = {WIDTH{1'b0}};
    res_cond_s  = 1'b0;
    res_bad_s   = 1'b0;
    res_of_s    = 1'b0;
    cc_we_s     = 1'b0;
    is_mul_s    = 1'b0;
    // CC register value before the edge drives the condition.
    cond_eval_s = eval_cond(ifun, zf_r, sf_r, of_r);
    case (icode)
      4'h2: begin
        res_val_s  = valA;
        res_cond_s = cond_eval_s[0];
        res_bad_s  = cond_eval_s[1];
      end
      4'h3: res_val_s = valC;
      4'h4, 4'h5: res_val_s = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0: begin
            res_val_s = valB + valA;
            res_of_s  = (valA[WIDTH-1] == valB[WIDTH-1]) &&
                        (res_val_s[WIDTH-1] != valB[WIDTH-1]);
            cc_we_s   = 1'b1;
          end
          4'h1: begin
            res_val_s = valB - valA;
            res_of_s  = (valA[WIDTH-1] != valB[WIDTH-1]) &&
                        (res_val_s[WIDTH-1] != valB[WIDTH-1]);
            cc_we_s   = 1'b1;
          end
          4'h2: begin
            res_val_s = valB & valA;
            cc_we_s   = 1'b1;
          end
          4'h3: begin
            res_val_s = valB ^ valA;
            cc_we_s   = 1'b1;
          end
          4'h4: begin
            if (MUL_EN) begin
              is_mul_s  = 1'b1;
            end else begin
              res_bad_s = 1'b1;
            end
          end
          default: res_bad_s = 1'b1;
        endcase
      end
      4'h7: begin
        res_cond_s = cond_eval_s[0];
        res_bad_s  = cond_eval_s[1];
      end
      4'h8, 4'hA: res_val_s = valB - WB_V;
      4'h9, 4'hB: res_val_s = valB + WB_V;
      default: res_val_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step of the multiply and detection of its final step.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    mul_last_s = (cnt_r == LAST_CNT);
  end

  // Stage state, output register, CC register and multiplier registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_icode_r <= 4'h0;
      val_e_r     <= {WIDTH{1'b0}};
      cond_r      <= 1'b0;
      bad_op_r    <= 1'b0;
      zf_r        <= 1'b1;
      sf_r        <= 1'b0;
      of_r        <= 1'b0;
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (is_mul_s) begin
              // The output register is free or draining here; it stays
              // empty until the multiply completes.
              state_r     <= ST_MUL;
              out_valid_r <= 1'b0;
              mcand_r     <= {{WIDTH{1'b0}}, valB};
              mplier_r    <= valA;
              acc_r       <= {(2*WIDTH){1'b0}};
              cnt_r       <= {CW{1'b0}};
            end else begin
              out_valid_r <= 1'b1;
              out_icode_r <= icode;
              val_e_r     <= res_val_s;
              cond_r      <= res_cond_s;
              bad_op_r    <= res_bad_s;
              if (cc_we_s) begin
                zf_r <= (res_val_s == {WIDTH{1'b0}});
                sf_r <= res_val_s[WIDTH-1];
                of_r <= res_of_s;
              end
            end
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (mul_last_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b1;
            out_icode_r <= 4'h6;
            val_e_r     <= acc_next_s[WIDTH-1:0];
            cond_r      <= 1'b0;
            bad_op_r    <= 1'b0;
            zf_r        <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            sf_r        <= acc_next_s[WIDTH-1];
            of_r        <= (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_icode = out_icode_r;
  assign valE      = val_e_r;
  assign cond      = cond_r;
  assign bad_op    = bad_op_r;
  assign ZF        = zf_r;
  assign SF        = sf_r;
  assign OF        = of_r;

endmodule

// File: tb/tb_exec_stage_hs.sv
module tb_exec_stage_hs;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] valE;
  logic        cond;
  logic        bad_op;
  logic        ZF;
  logic        SF;
  logic        OF;

  int errors = 0;
  int checks = 0;

  exec_stage_hs #(.WIDTH(64), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .valE      (valE),
    .cond      (cond),
    .bad_op    (bad_op),
    .ZF        (ZF),
    .SF        (SF),
    .OF        (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
    chk({tag, "_cc"}, {61'd0, ZF, SF, OF}, {61'd0, zf, sf, of});
  endtask

  task automatic set_op(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    in_valid = 1'b1;
    icode = ic;
    ifun  = fn;
    valA  = a;
    valB  = b;
    valC  = c;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h0; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valE", valE, 64'd0);
    chk("rst_flags", {60'd0, out_icode}, 64'd0);
    chk("rst_cond_bad", {62'd0, cond, bad_op}, 64'd0);
    chk_cc("rst", 1'b1, 1'b0, 1'b0);

    // sub: 3 - 5
    set_op(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
    tick();
    chk("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_valid_bad", {62'd0, out_valid, bad_op}, 64'd2);
    chk_cc("sub", 1'b0, 1'b1, 1'b0);

    // add overflow, then back-to-back jXX, cmovXX, pushq
    set_op(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    tick();
    chk("add_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk_cc("add", 1'b0, 1'b1, 1'b1);
    set_op(4'h7, 4'h2, 64'd0, 64'd0, 64'h40);
    tick();
    chk("jl_cond", {63'd0, cond}, 64'd0);
    chk("jl_icode_valE", {valE[59:0], out_icode}, 64'h7);
    set_op(4'h2, 4'h4, 64'h55, 64'd0, 64'd0);
    tick();
    chk("cmovne_cond", {63'd0, cond}, 64'd1);
    chk("cmovne_valE", valE, 64'h55);
    set_op(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    tick();
    chk("push_valE", valE, 64'hF8);
    chk_cc("push", 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // multiply 3 * 7
    set_op(4'h6, 4'h4, 64'd3, 64'd7, 64'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 64; i++) begin
      chk("mul1_busy", {62'd0, in_ready, out_valid}, 64'd0);
      tick();
    end
    chk("mul1_busy_last", {62'd0, in_ready, out_valid}, 64'd0);
    tick();
    chk("mul1_done", {62'd0, out_valid, in_ready}, 64'd3);
    chk("mul1_valE", valE, 64'd21);
    chk_cc("mul1", 1'b0, 1'b0, 1'b0);

    // multiply 2^32 * 2^32, accepted while the previous result drains
    set_op(4'h6, 4'h4, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 64; i++) tick();
    chk("mul2_pending", {63'd0, out_valid}, 64'd0);
    tick();
    chk("mul2_valid", {63'd0, out_valid}, 64'd1);
    chk("mul2_valE", valE, 64'd0);
    chk_cc("mul2", 1'b1, 1'b0, 1'b1);
    tick();

    // back-pressure with two irmovq
    out_ready = 1'b0;
    set_op(4'h3, 4'h0, 64'd0, 64'd0, 64'h11);
    tick();
    valC = 64'h22;
    chk("bp_first", valE, 64'h11);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_hold1", {valE[62:0], out_valid}, {63'h11, 1'b1});
    tick();
    chk("bp_hold2", valE, 64'h11);
    chk("bp_in_ready2", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_first", valE, 64'h11);
    tick();
    chk("bp_second", {valE[62:0], out_valid}, {63'h22, 1'b1});
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // illegal OPq ifun: CC keeps ZF=1 SF=0 OF=1 from the last multiply
    set_op(4'h6, 4'h7, 64'd9, 64'd9, 64'd0);
    tick();
    chk("ill_op", {valE[61:0], bad_op, out_valid}, 64'd3);
    chk_cc("ill_op", 1'b1, 1'b0, 1'b1);
    set_op(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    tick();
    chk("ill_cond", {62'd0, cond, bad_op}, 64'd1);
    in_valid = 1'b0;
    tick();

    // reset 10 cycles into a multiply
    set_op(4'h6, 4'h4, 64'd3, 64'd5, 64'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_state", {62'd0, out_valid, in_ready}, 64'd1);
    chk_cc("abort", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) tick();
    chk("abort_no_result", {63'd0, out_valid}, 64'd0);
    set_op(4'h6, 4'h0, 64'd2, 64'd3, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("post_abort_add", {valE[62:0], out_valid}, {63'd5, 1'b1});
    chk_cc("post_abort", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage_hs.md
# exec_stage_hs

Parametrised execute stage for the Y86-style processor: takes decoded instruction fields (`icode`, `ifun`, `valA`, `valB`, `valC`), computes `valE` and branch/move condition `cond`, and maintains the condition-code register (ZF/SF/OF). It generalises the single-cycle execute stage in three ways:
- a configurable datapath width;
- valid/ready handshakes on both sides, so it can sit between pipeline registers;
- an optional iterative multiply (`OPq` `ifun`=4) that occupies the stage for multiple cycles.

## Interface
Parameters:
- `WIDTH`, 64: datapath width in bits; multiple of 8, at least 16. `WB` = `WIDTH`/8 is the stack step.
- `MUL_EN`, 1: 1 enables `OPq` `ifun`=4 (multiply). 0 makes that encoding illegal.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream presents an instruction.
- `in_ready` out 1: stage accepts this cycle. Transfer occurs when `in_valid`&`in_ready` at the edge.
- `icode` in 4, `ifun` in 4: instruction codes.
- `valA`, `valB`, `valC` in `WIDTH`: operands, signed two's complement.
- `out_valid` out 1: result registers hold a valid result.
- `out_ready` in 1: downstream consumes. Transfer occurs when `out_valid`&`out_ready` at the edge.
- `out_icode` out 4: `icode` of the held result.
- `valE` out `WIDTH`: execute result.
- `cond` out 1: condition outcome for `cmovXX`/`jXX`.
- `bad_op` out 1: illegal `ifun` for this `icode`.
- `ZF`, `SF`, `OF` out 1 each: current condition-code register.

## Operation
- FSM states:
  - `IDLE`: may accept.
  - `MUL`: iterating; `in_ready`=0.
  - Output register is separate and tracked by `out_valid`.
- `in_ready` = (state==`IDLE`) & (!`out_valid` | `out_ready`).
- `valE` by `icode`:
  - 2 rrmov/cmov: `valA`.
  - 3 irmov: `valC`.
  - 4/5 rmmov/mrmov: `valB`+`valC`.
  - 6 `OPq`: `valB` op `valA`.
  - 8 call, A push: `valB`-`WB`.
  - 9 ret, B pop: `valB`+`WB`.
  - 0, 1, 7, C–F: 0.
- `OPq` `ifun` encodings:
  - 0: add.
  - 1: sub (`valB`-`valA`).
  - 2: and.
  - 3: xor.
  - 4: unsigned multiply, low `WIDTH` bits.
  - Other values, or 4 with `MUL_EN`=0: illegal, giving `valE`=0, `bad_op`=1, CC unchanged.
- CC update: only legal `OPq` updates CC. ZF=(result==0), SF=result[`WIDTH`-1]. OF by op:
  - add: operands same sign, result sign differs.
  - sub: `valB`/`valA` signs differ and result sign ≠ `valB` sign.
  - and/xor: 0.
  - mul: 1 iff upper `WIDTH` bits of full 2·`WIDTH` product nonzero.
- `cond` (`icode` 2 or 7), evaluated from CC register value *before* the accepting edge. By `ifun`:
  - 0: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - ≥7: `cond`=0, `bad_op`=1.
- `cond`=0 for all other `icode`s.
- Multiply: shift-add, one multiplier bit per cycle, `WIDTH` iterations, 2·`WIDTH`-bit accumulator, bit counter of clog2(`WIDTH`)+1 bits. No early termination.

## Timing
- Reset values:
  - `in_ready`=1 (the cycle after reset deasserts).
  - `out_valid`=0, `valE`=0, `cond`=0, `bad_op`=0, `out_icode`=0.
  - ZF=1, SF=0, OF=0.
  - state `IDLE`.
- Single-cycle ops: accepted at edge N gives `out_valid`=1 after N with all outputs; CC updated at the same edge N.
- Multiply: accepted at edge N. State `MUL` for edges N+1..N+`WIDTH`. Result and CC loaded at edge N+`WIDTH`, so `out_valid` is seen after that edge (latency `WIDTH` cycles). Returns to `IDLE` at the same edge.
- Back-pressure:
  - While `out_valid`&!`out_ready`, all outputs are held bit-stable and `in_ready`=0.
  - A simultaneous drain and accept is allowed: full throughput of 1 instruction/cycle for single-cycle ops.
- A multiply never completes into an occupied output register: accept requires the register free or draining.
- `rst` mid-multiply aborts:
  - No result emitted.
  - CC returns to reset values.
  - `in_ready`=1 the next cycle.
- `rst` has priority over every handshake at the same edge.
- Inputs are ignored when not accepted; no input is latched except on transfer.

## Test plan
- Reset, then idle: `out_valid`=0, ZF=1/SF=0/OF=0, `in_ready`=1, `valE`=0.
- `OPq` sub, `valA`=5, `valB`=3 → one cycle later `valE`=0xFFFF_FFFF_FFFF_FFFE, ZF=0, SF=1, OF=0, `bad_op`=0.
- `OPq` add, `valA`=`valB`=0x7FFF_FFFF_FFFF_FFFF → `valE`=0xFFFF_FFFF_FFFF_FFFE, SF=1, OF=1. Then back-to-back results:
  - `jXX` `ifun`=2 (l) → `cond`=0.
  - `cmovXX` `ifun`=4 (ne) → `cond`=1.
  - `pushq` `valB`=0x100 → `valE`=0xF8 with CC unchanged.
- Multiply: `valA`=3, `valB`=7 → `in_ready` low 64 cycles, then `valE`=21, ZF=0, OF=0. Then `valA`=`valB`=2^32 → `valE`=0, ZF=1, OF=1.
- Back-pressure: hold `out_ready`=0 with two `irmovq` (`valC`=0x11, 0x22) offered → 0x11 held stable and `in_ready`=0. Raising `out_ready` gives 0x11 then 0x22 on consecutive cycles.
- Illegal/abort cases:
  - `OPq` `ifun`=7 → `valE`=0, `bad_op`=1, CC unchanged.
  - `rst` 10 cycles into a multiply → no `out_valid`, CC = reset values, next `OPq` accepted normally.
